// File: rtl/csr_pkg.sv
// Shared CSR-side definitions for the RV32 core's machine-mode timer block.
// Holds the mip bit positions the timer lines feed, the byte offsets of the
// memory-mapped timer registers and the timer bus FSM state type.
package csr_pkg;

  // Bit positions in mip that the timer and software interrupt lines drive
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MSIP_BIT = 3;

  // Byte offsets inside the timer region
  localparam int unsigned MTIMER_OFF_MTIME_LO    = 32'h00;
  localparam int unsigned MTIMER_OFF_MTIME_HI    = 32'h04;
  localparam int unsigned MTIMER_OFF_MTIMECMP_LO = 32'h08;
  localparam int unsigned MTIMER_OFF_MTIMECMP_HI = 32'h0C;
  localparam int unsigned MTIMER_OFF_MSIP        = 32'h10;

  typedef enum logic {
    MTIMER_IDLE,
    MTIMER_RESP
  } mtimer_state_t;

endpackage

// File: rtl/mtime_prescaler.sv
// Tick generator for mtime: a modulo-PRESCALE down-counter that emits a
// single-cycle tick once every PRESCALE clock cycles. The first tick after
// reset lands so that mtime steps at clock edge PRESCALE.
//
// Ports:
//   clk   - core clock
//   nrst  - asynchronous active-low reset
//   tick  - one-cycle pulse, high in the cycle before mtime should increment
module mtime_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic nrst,
  output logic tick
);

  localparam logic [15:0] RELOAD  = 16'(PRESCALE - 1);
  // With PRESCALE=1 the count never leaves 0, so tick must sit on 0 there;
  // otherwise tick fires on the last count before the wrap back to 0.
  localparam logic [15:0] TICK_AT = (PRESCALE == 1) ? 16'd0 : 16'd1;

  logic [15:0] count;

  // Count down from 0 -> RELOAD -> ... -> 1 -> 0, repeating every PRESCALE cycles
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count <= '0;
    end else if (count == 16'd0) begin
      count <= RELOAD;
    end else begin
      count <= count - 16'd1;
    end
  end

  assign tick = (count == TICK_AT);

endmodule

// File: rtl/machine_timer.sv
// RISC-V machine timer: 64-bit mtime counter and mtimecmp comparator behind a
// word-wide load/store port. Drives mtip into the CSR/exception unit.
//
// Optional feature macro: MACHINE_TIMER_MSIP_EN
//   defined   - msip register at offset 0x10 and the msip output port exist
//   undefined - no msip; offset 0x10 is unmapped and answers with err
//
// Ports:
//   clk, nrst      - core clock, asynchronous active-low reset
//   req, wen       - bus request (held until ready) and write select
//   addr, wdata    - byte offset into the timer region, write data
//   rdata          - read data, valid only while ready is high
//   ready, err     - one-cycle response strobe and its error qualifier
//   mtip           - machine timer interrupt pending (registered compare)
//   msip           - machine software interrupt pending (feature only)
module machine_timer
  import csr_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic              err,
  output logic              mtip
`ifdef MACHINE_TIMER_MSIP_EN
  ,
  output logic              msip
`endif
);

  mtimer_state_t state;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic [63:0]   mtime_inc;
  logic [63:0]   mtime_next;
  logic [31:0]   offset;
  logic [31:0]   rd_word;
  logic          tick;
  logic          accept;
  logic          aligned;
  logic          sel_time_lo, sel_time_hi, sel_cmp_lo, sel_cmp_hi, sel_msip;
  logic          mapped;
`ifdef MACHINE_TIMER_MSIP_EN
  logic          msip_q;
`endif

  mtime_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .tick (tick)
  );

  assign offset  = 32'(addr);
  assign aligned = (addr[1:0] == 2'b00);
  // A request is only taken in IDLE; a req still high during RESP is ignored
  assign accept  = (state == MTIMER_IDLE) && req;

  assign sel_time_lo = aligned && (offset == MTIMER_OFF_MTIME_LO);
  assign sel_time_hi = aligned && (offset == MTIMER_OFF_MTIME_HI);
  assign sel_cmp_lo  = aligned && (offset == MTIMER_OFF_MTIMECMP_LO);
  assign sel_cmp_hi  = aligned && (offset == MTIMER_OFF_MTIMECMP_HI);
`ifdef MACHINE_TIMER_MSIP_EN
  assign sel_msip    = aligned && (offset == MTIMER_OFF_MSIP);
  assign msip        = msip_q;
`else
  assign sel_msip    = 1'b0;
`endif
  assign mapped = sel_time_lo | sel_time_hi | sel_cmp_lo | sel_cmp_hi | sel_msip;

  // Read mux over the current register values, i.e. before this cycle's tick
  always_comb begin
    rd_word = '0;
    if (sel_time_lo) rd_word = mtime[31:0];
    if (sel_time_hi) rd_word = mtime[63:32];
    if (sel_cmp_lo)  rd_word = mtimecmp[31:0];
    if (sel_cmp_hi)  rd_word = mtimecmp[63:32];
`ifdef MACHINE_TIMER_MSIP_EN
    if (sel_msip)    rd_word = {31'd0, msip_q};
`endif
  end

  // Tick increment first, then a bus write overrides only its own half; the
  // untouched half keeps the tick's carry result.
  always_comb begin
    mtime_inc  = mtime + 64'(tick);
    mtime_next = mtime_inc;
    if (accept && wen && sel_time_lo) mtime_next[31:0]  = wdata;
    if (accept && wen && sel_time_hi) mtime_next[63:32] = wdata;
  end

  // Counter and registered compare against the current register values
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mtime <= '0;
      mtip  <= 1'b0;
    end else begin
      mtime <= mtime_next;
      mtip  <= (mtime >= mtimecmp);
    end
  end

  // Bus FSM with registered response; also owns the software-written registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= MTIMER_IDLE;
      ready    <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      mtimecmp <= '1;
`ifdef MACHINE_TIMER_MSIP_EN
      msip_q   <= 1'b0;
`endif
    end else begin
      case (state)
        MTIMER_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
          if (req) begin
            state <= MTIMER_RESP;
            ready <= 1'b1;
            err   <= ~mapped;
            rdata <= (!wen && mapped) ? rd_word : 32'd0;
            if (wen && sel_cmp_lo) mtimecmp[31:0]  <= wdata;
            if (wen && sel_cmp_hi) mtimecmp[63:32] <= wdata;
`ifdef MACHINE_TIMER_MSIP_EN
            if (wen && sel_msip)   msip_q          <= wdata[0];
`endif
          end
        end
        default: begin
          state <= MTIMER_IDLE;
          ready <= 1'b0;
          err   <= 1'b0;
          rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_machine_timer.sv
// Self-checking bench for machine_timer (PRESCALE=1). Stimulus pushes the
// expected response into a queue; a monitor pops and compares on ready.
// mtip is compared every cycle against a small behavioural timer model.
module tb_machine_timer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req = 1'b0;
  logic        wen = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ready, err, mtip;
`ifdef MACHINE_TIMER_MSIP_EN
  logic        msip;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        chk_rd;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state and pending-write strobes set by the stimulus
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_mtip;
  logic        pw_time_lo = 1'b0, pw_time_hi = 1'b0, pw_cmp_lo = 1'b0, pw_cmp_hi = 1'b0;
  logic [31:0] pw_data = '0;

  always #5 clk = ~clk;

  machine_timer #(
    .PRESCALE (1),
    .ADDR_W   (5)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .req   (req),
    .wen   (wen),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .err   (err),
    .mtip  (mtip)
`ifdef MACHINE_TIMER_MSIP_EN
    ,
    .msip  (msip)
`endif
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: mtime steps every cycle; an accepted write replaces its half only
  always @(posedge clk or negedge nrst) begin : model
    logic [63:0] nxt;
    if (!nrst) begin
      m_time <= '0;
      m_cmp  <= '1;
      m_mtip <= 1'b0;
    end else begin
      nxt = m_time + 64'd1;
      if (pw_time_lo) nxt[31:0]  = pw_data;
      if (pw_time_hi) nxt[63:32] = pw_data;
      m_time <= nxt;
      if (pw_cmp_lo) m_cmp[31:0]  <= pw_data;
      if (pw_cmp_hi) m_cmp[63:32] <= pw_data;
      m_mtip <= (m_time >= m_cmp);
    end
  end

  // Monitor: pop one expectation per ready strobe, and track mtip each cycle
  always @(negedge clk) begin
    exp_t e;
    if (nrst) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_ready", 64'(ready), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_output({e.name, "_err"}, 64'(err), 64'(e.err));
          if (e.chk_rd) check_output({e.name, "_rdata"}, 64'(rdata), 64'(e.rdata));
        end
      end
      check_output("mtip", 64'(mtip), 64'(m_mtip));
    end
  end

  // One bus transfer: accept on the next edge, then sit out the RESP cycle
  task automatic apply_stimulus(input logic w, input logic [4:0] a, input logic [31:0] d,
                                input logic [31:0] exp_rd, input logic exp_err,
                                input logic use_model, input string name);
    exp_t e;
    @(negedge clk);
    req = 1'b1;
    wen = w;
    addr = a;
    wdata = d;
    pw_data = d;
    if (w && !exp_err) begin
      pw_time_lo = (a == 5'h00);
      pw_time_hi = (a == 5'h04);
      pw_cmp_lo  = (a == 5'h08);
      pw_cmp_hi  = (a == 5'h0C);
    end
    e.rdata  = use_model ? ((a == 5'h04) ? m_time[63:32] : m_time[31:0]) : exp_rd;
    e.err    = exp_err;
    e.chk_rd = !w;
    e.name   = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req = 1'b0;
    wen = 1'b0;
    pw_time_lo = 1'b0;
    pw_time_hi = 1'b0;
    pw_cmp_lo  = 1'b0;
    pw_cmp_hi  = 1'b0;
    @(posedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    exp_t e;
    // Reset values while nrst is held low
    repeat (3) @(negedge clk);
    check_output("rst_ready", 64'(ready), 64'd0);
    check_output("rst_err",   64'(err),   64'd0);
    check_output("rst_rdata", 64'(rdata), 64'd0);
    check_output("rst_mtip",  64'(mtip),  64'd0);
    nrst = 1'b1;

    // Ten idle cycles, then mtime_lo must read 10
    repeat (10) @(posedge clk);
    apply_stimulus(1'b0, 5'h00, 32'd0, 32'd10, 1'b0, 1'b0, "idle10_mtime_lo");

    // Compare point at 20: mtip rises one cycle after mtime reaches it
    apply_stimulus(1'b1, 5'h0C, 32'd0,  32'd0, 1'b0, 1'b0, "wr_cmp_hi");
    apply_stimulus(1'b1, 5'h08, 32'd20, 32'd0, 1'b0, 1'b0, "wr_cmp_lo20");
    apply_stimulus(1'b0, 5'h08, 32'd0,  32'd20, 1'b0, 1'b0, "rd_cmp_lo20");
    repeat (8) @(posedge clk);
    check_output("mtip_after_20", 64'(mtip), 64'd1);
    apply_stimulus(1'b1, 5'h08, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "wr_cmp_lo_max");
    apply_stimulus(1'b0, 5'h08, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "rd_cmp_lo_max");
    check_output("mtip_fell", 64'(mtip), 64'd0);

    // Unmapped and misaligned accesses leave everything untouched
    apply_stimulus(1'b0, 5'h14, 32'd0, 32'd0, 1'b1, 1'b0, "rd_unmapped14");
    apply_stimulus(1'b0, 5'h02, 32'd0, 32'd0, 1'b1, 1'b0, "rd_misaligned02");
    apply_stimulus(1'b1, 5'h0A, 32'd0, 32'd0, 1'b1, 1'b0, "wr_misaligned0a");
    apply_stimulus(1'b0, 5'h08, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "rd_cmp_lo_kept");

`ifdef MACHINE_TIMER_MSIP_EN
    apply_stimulus(1'b1, 5'h10, 32'd1, 32'd0, 1'b0, 1'b0, "wr_msip1");
    @(negedge clk);
    check_output("msip_set", 64'(msip), 64'd1);
    apply_stimulus(1'b0, 5'h10, 32'd0, 32'd1, 1'b0, 1'b0, "rd_msip1");
    apply_stimulus(1'b1, 5'h10, 32'd0, 32'd0, 1'b0, 1'b0, "wr_msip0");
    @(negedge clk);
    check_output("msip_clr", 64'(msip), 64'd0);
`else
    apply_stimulus(1'b0, 5'h10, 32'd0, 32'd0, 1'b1, 1'b0, "rd_msip_absent");
    apply_stimulus(1'b1, 5'h10, 32'd1, 32'd0, 1'b1, 1'b0, "wr_msip_absent");
`endif

    // req held high: ready must strobe every second cycle
    @(negedge clk);
    req = 1'b1;
    wen = 1'b0;
    addr = 5'h08;
    for (int i = 0; i < 3; i++) begin
      e.rdata = 32'hFFFF_FFFF;
      e.err = 1'b0;
      e.chk_rd = 1'b1;
      e.name = "hold_rd";
      exp_q.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("hold_ready", 64'(ready), (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    req = 1'b0;

    // Carry from low to high half
    apply_stimulus(1'b1, 5'h04, 32'd0,         32'd0, 1'b0, 1'b0, "wr_time_hi0");
    apply_stimulus(1'b1, 5'h00, 32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0, "wr_time_lo_fffe");
    apply_stimulus(1'b0, 5'h04, 32'd0, 32'd0, 1'b0, 1'b1, "rd_hi_before_carry");
    apply_stimulus(1'b0, 5'h00, 32'd0, 32'd0, 1'b0, 1'b1, "rd_lo_after_carry");
    apply_stimulus(1'b0, 5'h04, 32'd0, 32'd1, 1'b0, 1'b0, "rd_hi_after_carry");

    // Full 64-bit wrap from all-ones to zero
    apply_stimulus(1'b1, 5'h04, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "wr_time_hi_max");
    apply_stimulus(1'b1, 5'h00, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, "wr_time_lo_max");
    apply_stimulus(1'b0, 5'h04, 32'd0, 32'd0, 1'b0, 1'b0, "rd_hi_wrapped");
    apply_stimulus(1'b0, 5'h00, 32'd0, 32'd0, 1'b0, 1'b1, "rd_lo_wrapped");

    // Write on a tick cycle wins: 5 written, one more tick before the read
    apply_stimulus(1'b1, 5'h00, 32'd5, 32'd0, 1'b0, 1'b0, "wr_time_lo5");
    apply_stimulus(1'b0, 5'h00, 32'd0, 32'd6, 1'b0, 1'b0, "rd_time_lo_after5");

    // Reset in the RESP cycle: no ready, and the accepted write is lost
    @(negedge clk);
    req = 1'b1;
    wen = 1'b1;
    addr = 5'h08;
    wdata = 32'h0000_1234;
    @(posedge clk);
    #1;
    nrst = 1'b0;
    req = 1'b0;
    wen = 1'b0;
    @(negedge clk);
    check_output("midrst_ready", 64'(ready), 64'd0);
    check_output("midrst_mtip",  64'(mtip),  64'd0);
    @(negedge clk);
    nrst = 1'b1;
    apply_stimulus(1'b0, 5'h08, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "rd_cmp_lo_after_rst");
    apply_stimulus(1'b0, 5'h0C, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, "rd_cmp_hi_after_rst");
    apply_stimulus(1'b0, 5'h00, 32'd0, 32'd0, 1'b0, 1'b1, "rd_time_lo_after_rst");

    repeat (3) @(posedge clk);
    check_output("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
